analysis: RTL and testbench

- Registered WIDTH-bit arithmetic/logic unit with status flags.
- A 2-bit opcode S selects add, subtract, AND or OR on operands X and Y.
- Result F and flags (carry-out, signed overflow, zero, negative) are captured on the clock edge.
- Used as the ALU datapath stage; one result per clock, no handshake.

---
 rtl/analysis_if.sv | 23 ++
 rtl/analysis.sv | 55 +++++
 tb/tb_analysis.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/analysis_if.sv
// Operand/opcode and registered result/flag bundle for the analysis ALU stage.
interface analysis_if #(
   parameter int WIDTH = 5
);
   logic [1:0]       S;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] F;
   logic             cout;
   logic             overflow;
   logic             zero;
   logic             negative;

   modport master (
      output S, X, Y,
      input  F, cout, overflow, zero, negative
   );

   modport slave (
      input  S, X, Y,
      output F, cout, overflow, zero, negative
   );
endinterface

// File: rtl/analysis.sv
// Registered WIDTH-bit ALU: add, subtract, AND, OR with carry, overflow, zero and negative flags.
module analysis #(
   parameter int WIDTH = 5
) (
   input logic       clk,
   input logic       rst_n,
   analysis_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] r;
   logic             c;
   logic             ov;

   always_comb begin
      sum = '0;
      r   = '0;
      c   = 1'b0;
      ov  = 1'b0;
      case (bus.S)
         2'b00: begin
            sum = {1'b0, bus.X} + {1'b0, bus.Y};
            r   = sum[MSB:0];
            c   = sum[WIDTH];
            ov  = (bus.X[MSB] == bus.Y[MSB]) && (r[MSB] != bus.X[MSB]);
         end
         2'b01: begin
            // carry out of X + ~Y + 1 is the no-borrow indication
            sum = {1'b0, bus.X} + {1'b0, ~bus.Y} + {{WIDTH{1'b0}}, 1'b1};
            r   = sum[MSB:0];
            c   = sum[WIDTH];
            ov  = (bus.X[MSB] != bus.Y[MSB]) && (r[MSB] != bus.X[MSB]);
         end
         2'b10:   r = bus.X & bus.Y;
         default: r = bus.X | bus.Y;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.F        <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
         bus.zero     <= 1'b0;
         bus.negative <= 1'b0;
      end else begin
         bus.F        <= r;
         bus.cout     <= c;
         bus.overflow <= ov;
         bus.zero     <= (r == '0);
         bus.negative <= r[MSB];
      end
   end
endmodule

// File: tb/tb_analysis.sv
// Self-checking bench for analysis: directed literal vectors plus an exhaustive sweep against an arithmetic model.
module tb_analysis;
   localparam int W = 5;
   localparam int M = 1 << W;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   analysis_if #(.WIDTH(W)) bus ();

   analysis #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference from integer arithmetic: unsigned range for carry, signed range for overflow.
   task automatic model(input int s, input int x, input int y,
                        output int f, output int c, output int ov, output int z, output int n);
      int sx, sy, r, sr;
      sx = (x >= M/2) ? x - M : x;
      sy = (y >= M/2) ? y - M : y;
      c  = 0;
      ov = 0;
      case (s)
         0: begin
            r  = x + y;
            c  = (r >= M) ? 1 : 0;
            sr = sx + sy;
            ov = (sr > M/2 - 1 || sr < -M/2) ? 1 : 0;
         end
         1: begin
            r  = x - y + M;
            c  = (x >= y) ? 1 : 0;
            sr = sx - sy;
            ov = (sr > M/2 - 1 || sr < -M/2) ? 1 : 0;
         end
         2:       r = x & y;
         default: r = x | y;
      endcase
      f = r % M;
      z = (f == 0) ? 1 : 0;
      n = (f >= M/2) ? 1 : 0;
   endtask

   // Per-edge comparison of every output against the model of the inputs sampled at that edge.
   always @(posedge clk) begin
      int rs, s, x, y, ef, ec, eo, ez, en;
      rs = int'(rst_n);
      s  = int'(bus.S);
      x  = int'(bus.X);
      y  = int'(bus.Y);
      #1;
      if (rs == 0) begin
         ef = 0; ec = 0; eo = 0; ez = 0; en = 0;
      end else begin
         model(s, x, y, ef, ec, eo, ez, en);
      end
      chk("cyc_F",        int'(bus.F),        ef);
      chk("cyc_cout",     int'(bus.cout),     ec);
      chk("cyc_overflow", int'(bus.overflow), eo);
      chk("cyc_zero",     int'(bus.zero),     ez);
      chk("cyc_negative", int'(bus.negative), en);
   end

   task automatic vec(input string name, input logic [1:0] s, input logic [4:0] x, input logic [4:0] y,
                      input logic [4:0] ef, input bit ec, input bit eo, input bit ez, input bit en);
      @(negedge clk);
      bus.S = s;
      bus.X = x;
      bus.Y = y;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_F"},   int'(bus.F),        int'(ef));
      chk({name, "_c"},   int'(bus.cout),     int'(ec));
      chk({name, "_ov"},  int'(bus.overflow), int'(eo));
      chk({name, "_z"},   int'(bus.zero),     int'(ez));
      chk({name, "_n"},   int'(bus.negative), int'(en));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.S = 2'b00;
      bus.X = 5'b11111;
      bus.Y = 5'b00001;
      @(posedge clk);
      @(negedge clk);
      chk("rst_F",    int'(bus.F),        0);
      chk("rst_c",    int'(bus.cout),     0);
      chk("rst_ov",   int'(bus.overflow), 0);
      chk("rst_z",    int'(bus.zero),     0);
      chk("rst_n",    int'(bus.negative), 0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rel_F",    int'(bus.F),        0);
      chk("rel_c",    int'(bus.cout),     1);
      chk("rel_ov",   int'(bus.overflow), 0);
      chk("rel_z",    int'(bus.zero),     1);

      vec("add_ovf",  2'b00, 5'b01111, 5'b00001, 5'b10000, 0, 1, 0, 1);
      vec("sub_brw",  2'b01, 5'b00011, 5'b00101, 5'b11110, 0, 0, 0, 1);
      vec("sub_ovf",  2'b01, 5'b10000, 5'b00001, 5'b01111, 1, 1, 0, 0);
      vec("and",      2'b10, 5'b10110, 5'b01110, 5'b00110, 0, 0, 0, 0);
      vec("or",       2'b11, 5'b10110, 5'b01110, 5'b11110, 0, 0, 0, 1);
      vec("sub_zero", 2'b01, 5'b10101, 5'b10101, 5'b00000, 1, 0, 1, 0);
      vec("add_neg",  2'b00, 5'b11111, 5'b11111, 5'b11110, 1, 0, 0, 1);
      vec("add_min",  2'b00, 5'b10000, 5'b10000, 5'b00000, 1, 1, 1, 0);

      // A reset pulse wholly between edges must not disturb the next result.
      @(negedge clk);
      bus.S = 2'b00;
      bus.X = 5'b00001;
      bus.Y = 5'b00001;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("glitch_F", int'(bus.F), 2);

      for (int s = 0; s < 4; s++) begin
         for (int x = 0; x < M; x++) begin
            for (int y = 0; y < M; y++) begin
               @(negedge clk);
               bus.S = 2'(s);
               bus.X = 5'(x);
               bus.Y = 5'(y);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
